// File: rtl/siftedkey_reader_if.sv
// Bundle of the BRAM port-B read signals and the downstream key word stream.
interface siftedkey_reader_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] Asiftedkey_addrb;
    logic              Asiftedkey_enb;
    logic [DATA_W-1:0] Asiftedkey_doutb;
    logic [DATA_W-1:0] key_tdata;
    logic              key_tvalid;
    logic              key_tready;
    logic              key_tlast;

    // The reader drives the BRAM address/enable and the outgoing stream.
    modport master (
        output Asiftedkey_addrb,
        output Asiftedkey_enb,
        input  Asiftedkey_doutb,
        output key_tdata,
        output key_tvalid,
        input  key_tready,
        output key_tlast
    );

    // The BRAM / downstream consumer side.
    modport slave (
        input  Asiftedkey_addrb,
        input  Asiftedkey_enb,
        output Asiftedkey_doutb,
        input  key_tdata,
        input  key_tvalid,
        output key_tready,
        input  key_tlast
    );
endinterface

// File: rtl/siftedkey_reader.sv
// Sifted-key burst reader: fetches key_words consecutive words from the
// sifted-key BRAM (port B) and streams them out with valid/ready flow control.
// A credit counter (words in flight plus words buffered) guarantees the small
// output FIFO can never overflow, whatever the downstream ready pattern is.
module siftedkey_reader #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 64,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [15:0]       key_words,
    output logic              busy,
    output logic              done,
    siftedkey_reader_if.master bus
);

    localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] MAX_WORDS = 16'd32768;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       rem_q, rem_d;
    logic [CNT_W-1:0]  used_q, used_d;
    logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0] last_pipe_q, last_pipe_d;
    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [15:0]       req_words;
    logic              fifo_pop;
    logic              fifo_push;
    logic              head_last;
    logic              room;
    logic              issue;
    logic              issue_last;
    logic [ADDR_W-1:0] issue_addr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Clamp the requested length to the BRAM depth and derive handshake terms.
    always_comb begin
        req_words = (key_words > MAX_WORDS) ? MAX_WORDS : key_words;
        fifo_pop  = (count_q != '0) && bus.key_tready;
        fifo_push = vld_pipe_q[RD_LAT-1];
        head_last = mem_q[rd_ptr_q][DATA_W];
        room      = (used_q < CNT_W'(FIFO_DEPTH)) || fifo_pop;
    end

    // Read issue: the first read goes out in the accepting cycle, then one per cycle while credit allows.
    always_comb begin
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_addr = addr_q;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (start && (req_words != 16'd0)) begin
                        issue      = 1'b1;
                        issue_addr = start_addr;
                        issue_last = (req_words == 16'd1);
                    end
                end
                READ: begin
                    if (room) begin
                        issue      = 1'b1;
                        issue_last = (rem_q == 16'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (req_words == 16'd0)      state_d = DONE;
                    else if (req_words == 16'd1) state_d = DRAIN;
                    else                         state_d = READ;
                end
            end
            READ:    if (issue && issue_last)     state_d = DRAIN;
            DRAIN:   if (fifo_pop && head_last)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Address/remaining counters, credit tracking and the returning-data valid delay line.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if ((state_q == IDLE) && start) begin
            addr_d = start_addr;
            rem_d  = req_words;
        end
        if (issue) begin
            addr_d = issue_addr + ADDR_W'(1);
            rem_d  = ((state_q == IDLE) ? req_words : rem_q) - 16'd1;
        end
        used_d         = used_q + CNT_W'(issue) - CNT_W'(fifo_pop);
        vld_pipe_d     = vld_pipe_q;
        last_pipe_d    = last_pipe_q;
        vld_pipe_d[0]  = issue;
        last_pipe_d[0] = issue_last;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
    end

    // Output FIFO: capture BRAM data as its valid flag leaves the delay line, pop on handshake.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_push) begin
            mem_d[wr_ptr_q] = {last_pipe_q[RD_LAT-1], bus.Asiftedkey_doutb};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (fifo_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end

    // Datapath registers; reset also flushes in-flight reads so late BRAM data is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            rem_q       <= '0;
            used_q      <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            used_q      <= used_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage needs no reset: an empty count masks its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.Asiftedkey_enb   = issue;
    assign bus.Asiftedkey_addrb = issue ? issue_addr : '0;
    assign bus.key_tvalid       = (count_q != '0);
    assign bus.key_tdata        = mem_q[rd_ptr_q][DATA_W-1:0];
    assign bus.key_tlast        = head_last && (count_q != '0);

endmodule
